// File: rtl/sbitstream_pkg.sv
// Shared definitions for the stochastic bitstream generator and its neighbours
// (the LFSR instance in the parent and the downstream stochastic operators).
//   WIDTH_DEFAULT  : default magnitude / random-word width
//   LENGTH_DEFAULT : default number of bits per stream
//   state_t        : generator FSM states
package sbitstream_pkg;

    localparam int WIDTH_DEFAULT  = 20;
    localparam int LENGTH_DEFAULT = 1024;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sbitstream_generator_if.sv
// Load and bit-stream channels of the stochastic bitstream generator.
//   load channel : load_valid / load_ready with value_sign, value_mag
//   bit channel  : bit_valid / bit_ready with bit_pos, bit_neg, bit_last
//   done         : one-cycle pulse after the final bit of a stream is taken
// Modports:
//   master : the surrounding system (offers values, consumes bits)
//   slave  : the generator itself
interface sbitstream_generator_if #(
    parameter int WIDTH = sbitstream_pkg::WIDTH_DEFAULT
);
    logic             load_valid;
    logic             load_ready;
    logic             value_sign;
    logic [WIDTH-1:0] value_mag;
    logic             bit_valid;
    logic             bit_ready;
    logic             bit_pos;
    logic             bit_neg;
    logic             bit_last;
    logic             done;

    modport master (
        output load_valid, value_sign, value_mag, bit_ready,
        input  load_ready, bit_valid, bit_pos, bit_neg, bit_last, done
    );

    modport slave (
        input  load_valid, value_sign, value_mag, bit_ready,
        output load_ready, bit_valid, bit_pos, bit_neg, bit_last, done
    );
endinterface

// File: rtl/sbitstream_generator.sv
// Sign-magnitude to split-unipolar stochastic bitstream converter.
// Each produced bit compares the latched magnitude against the random word r;
// the result is steered to the positive or negative channel by the sign.
// Ports:
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset
//   r    : pseudorandom word from the upstream LFSR, new every cycle
//   bus  : load and bit channels (slave side of sbitstream_generator_if)
module sbitstream_generator
    import sbitstream_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int LENGTH = LENGTH_DEFAULT
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [WIDTH-1:0]   r,
    sbitstream_generator_if.slave bus
);

    localparam int             CW       = $clog2(LENGTH + 1);
    localparam logic [CW-1:0]  LEN_C    = CW'(LENGTH);
    localparam logic [CW-1:0]  LAST_IDX = CW'(LENGTH - 1);

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg;
    logic              sign_reg;
    logic [WIDTH-1:0]  mag_reg;
    logic              bit_valid_reg;
    logic              bit_pos_reg;
    logic              bit_neg_reg;
    logic              bit_last_reg;
    logic              done_reg;
    logic              load_ready;

    logic              load_fire;
    logic              adv;
    logic              end_fire;
    logic              gen;
    logic              cmp;

    assign load_fire = load_ready && bus.load_valid;
    // Output register may advance when empty or when its bit is being taken.
    assign adv       = !bit_valid_reg || bus.bit_ready;
    assign end_fire  = (state_reg == RUN) && bit_valid_reg && bus.bit_ready && bit_last_reg;
    assign gen       = (state_reg == RUN) && adv && (cnt_reg < LEN_C) && !end_fire;
    // r only reaches a register input, never an output directly.
    assign cmp       = (r < mag_reg);

    // FSM: state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state and load_ready
    always_comb begin
        state_next = state_reg;
        load_ready = 1'b0;
        case (state_reg)
            IDLE: begin
                load_ready = 1'b1;
                if (bus.load_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (end_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latched value, bit counter and output bit register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_reg       <= '0;
            sign_reg      <= 1'b0;
            mag_reg       <= '0;
            bit_valid_reg <= 1'b0;
            bit_pos_reg   <= 1'b0;
            bit_neg_reg   <= 1'b0;
            bit_last_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (load_fire) begin
                sign_reg <= bus.value_sign;
                mag_reg  <= bus.value_mag;
                cnt_reg  <= '0;
            end
            if (end_fire) begin
                bit_valid_reg <= 1'b0;
                bit_pos_reg   <= 1'b0;
                bit_neg_reg   <= 1'b0;
                bit_last_reg  <= 1'b0;
                done_reg      <= 1'b1;
            end else if (gen) begin
                bit_valid_reg <= 1'b1;
                bit_pos_reg   <= cmp && !sign_reg;
                bit_neg_reg   <= cmp && sign_reg;
                bit_last_reg  <= (cnt_reg == LAST_IDX);
                cnt_reg       <= cnt_reg + 1'b1;
            end
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.bit_valid  = bit_valid_reg;
    assign bus.bit_pos    = bit_pos_reg;
    assign bus.bit_neg    = bit_neg_reg;
    assign bus.bit_last   = bit_last_reg;
    assign bus.done       = done_reg;

endmodule
